// File: rtl/freq_meter_gated.sv
// Multi-channel gated frequency counter.
// Each channel's asynchronous input is synchronised and edge-detected. Rising
// edges are counted over a programmable window of clk cycles. At the end of
// each window the per-channel counts, the saturation flags and the window
// length are published together with a one-cycle valid strobe.
module freq_meter_gated #(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        sig,
  input  logic [GATE_W-1:0]      gate_len,
  input  logic                   start,
  input  logic                   continuous,
  output logic                   busy,
  output logic                   result_valid,
  output logic [N_CH*CNT_W-1:0]  result,
  output logic [N_CH-1:0]        overflow,
  output logic [GATE_W-1:0]      gate_used
);

  typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [N_CH-1:0]         sync1_q, sync2_q, dly_q;
  logic [N_CH-1:0]         edge_pulse;
  logic [N_CH*CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic [N_CH-1:0]         ovf_pend_q, ovf_pend_d, ovf_pend_nxt;
  logic [GATE_W-1:0]       gate_reg_q, gate_reg_d;
  logic [GATE_W-1:0]       gate_cnt_q, gate_cnt_d;
  logic                    cont_q, cont_d;
  logic [N_CH*CNT_W-1:0]   result_q, result_d;
  logic [N_CH-1:0]         overflow_q, overflow_d;
  logic [GATE_W-1:0]       gate_used_q, gate_used_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;

  // The delay flop sits behind the synchroniser, so a held-high level yields
  // exactly one pulse per rising edge.
  assign edge_pulse = sync2_q & ~dly_q;

  // Per-channel saturating increment, including this cycle's pulse.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    cnt_nxt      = cnt_q;
    ovf_pend_nxt = ovf_pend_q;
    for (int k = 0; k < N_CH; k++) begin
      if (edge_pulse[k]) begin
        if (&cnt_q[k*CNT_W +: CNT_W]) begin
          ovf_pend_nxt[k] = 1'b1;
        end else begin
          cnt_nxt[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_ONE;
        end
      end
    end
  end

  // Next-state and datapath control for IDLE -> ARM -> GATE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    gate_reg_d  = gate_reg_q;
    gate_cnt_d  = gate_cnt_q;
    cont_d      = cont_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    gate_used_d = gate_used_q;
    valid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = ARM;
      end
      ARM: begin
        // A zero-length gate would never terminate; run it as one cycle.
        gate_reg_d = (gate_len == '0) ? GATE_ONE : gate_len;
        cont_d     = continuous;
        cnt_d      = '0;
        ovf_pend_d = '0;
        gate_cnt_d = '0;
        state_d    = GATE;
      end
      GATE: begin
        cnt_d      = cnt_nxt;
        ovf_pend_d = ovf_pend_nxt;
        gate_cnt_d = gate_cnt_q + GATE_ONE;
        if (gate_cnt_q == gate_reg_q - GATE_ONE) begin
          result_d    = cnt_nxt;
          overflow_d  = ovf_pend_nxt;
          gate_used_d = gate_reg_q;
          valid_d     = 1'b1;
          state_d     = cont_q ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered busy tracks the state being entered.
    busy_d = (state_d != IDLE);
  end

  // State, synchroniser and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      dly_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= '0;
      gate_reg_q  <= '0;
      gate_cnt_q  <= '0;
      cont_q      <= 1'b0;
      result_q    <= '0;
      overflow_q  <= '0;
      gate_used_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // this is what makes the synchroniser a real two-stage chain.
      state_q     <= state_d;
      sync1_q     <= sig;
      sync2_q     <= sync1_q;
      dly_q       <= sync2_q;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      gate_reg_q  <= gate_reg_d;
      gate_cnt_q  <= gate_cnt_d;
      cont_q      <= cont_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      gate_used_q <= gate_used_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign overflow     = overflow_q;
  assign gate_used    = gate_used_q;

endmodule

// File: tb/tb_freq_meter_gated.sv
// Self-checking bench for freq_meter_gated: a default-width instance and a
// 4-bit-counter instance for saturation, each with an expected-result queue.
module tb_freq_meter_gated;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  ovf;
    logic [15:0] gu;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sig;
  logic [15:0] gate_len;
  logic        start, start_s, continuous;

  logic        busy, result_valid;
  logic [31:0] result;
  logic [1:0]  overflow;
  logic [15:0] gate_used;

  logic        busy_s, result_valid_s;
  logic [7:0]  result_s;
  logic [1:0]  overflow_s;
  logic [15:0] gate_used_s;

  exp_t        sb_q[$];
  exp_t        sb_s[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_strobe = 0;
  int          exp_strobe = 0;
  int          cyc = 0;
  int          t_arm, t_prev, lat;
  bit          ok;
  int          per[2];
  int          ph[2];

  freq_meter_gated #(.N_CH(2), .CNT_W(16), .GATE_W(16)) u_dut (
    .clk(clk), .rst(rst), .sig(sig), .gate_len(gate_len), .start(start),
    .continuous(continuous), .busy(busy), .result_valid(result_valid),
    .result(result), .overflow(overflow), .gate_used(gate_used)
  );

  freq_meter_gated #(.N_CH(2), .CNT_W(4), .GATE_W(16)) u_sat (
    .clk(clk), .rst(rst), .sig(sig), .gate_len(gate_len), .start(start_s),
    .continuous(1'b0), .busy(busy_s), .result_valid(result_valid_s),
    .result(result_s), .overflow(overflow_s), .gate_used(gate_used_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Periodic signal generator: rising edge once every per[ch] cycles (0 = low).
  initial begin
    sig = '0; ph[0] = 0; ph[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 2; ch++) begin
        if (per[ch] == 0) begin
          sig[ch] = 1'b0;
          ph[ch]  = 0;
        end else begin
          if (ph[ch] >= per[ch]) ph[ch] = 0;
          sig[ch] = (ph[ch] < per[ch] / 2);
          ph[ch]  = (ph[ch] + 1) % per[ch];
        end
      end
    end
  end

  // Scoreboard for the default instance.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      exp_t e;
      n_strobe++;
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("gate_used", 32'(gate_used), 32'(e.gu));
      end
    end
  end

  // Scoreboard for the saturating instance.
  always @(negedge clk) begin
    if (!rst && result_valid_s) begin
      exp_t e;
      chk("sat_sb_nonempty", 32'(sb_s.size() > 0), 32'd1);
      if (sb_s.size() > 0) begin
        e = sb_s.pop_front();
        chk("sat_result", 32'(result_s), e.res);
        chk("sat_overflow", 32'(overflow_s), 32'(e.ovf));
        chk("sat_gate_used", 32'(gate_used_s), 32'(e.gu));
      end
    end
  end

  task automatic push(input logic [31:0] res, input logic [1:0] ovf, input logic [15:0] gu);
    exp_t e;
    e.res = res; e.ovf = ovf; e.gu = gu;
    sb_q.push_back(e);
    exp_strobe++;
  endtask

  // Pulse start for one cycle; returns at the negedge following the ARM entry.
  task automatic start_meas(input logic [15:0] len, input logic cont);
    @(negedge clk);
    gate_len = len; continuous = cont; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_arm = cyc;
  endtask

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (result_valid) found = 1'b1;
    end
  endtask

  initial begin
    exp_t es;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; continuous = 1'b0;
    gate_len = '0; per[0] = 0; per[1] = 0;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_gate_used", 32'(gate_used), 32'd0);
    chk("rst_sat_result", 32'(result_s), 32'd0);
    rst = 1'b0;

    // Gate 100, ch0 edge every 10 clk, ch1 low.
    per[0] = 10; per[1] = 0;
    repeat (25) @(negedge clk);
    push({16'd0, 16'd10}, 2'b00, 16'd100);
    start_meas(16'd100, 1'b0);
    chk("t1_busy_arm", 32'(busy), 32'd1);
    wait_valid(300, ok);
    chk("t1_strobe_seen", 32'(ok), 32'd1);
    chk("t1_latency", 32'(cyc - t_arm), 32'd101);
    chk("t1_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_strobe_one_cycle", 32'(result_valid), 32'd0);
    chk("t1_result_hold", result, 32'd10);

    // Saturation on the 4-bit instance.
    per[0] = 2; per[1] = 8;
    repeat (20) @(negedge clk);
    es.res = {24'd0, 4'd8, 4'd15}; es.ovf = 2'b01; es.gu = 16'd64;
    sb_s.push_back(es);
    @(negedge clk);
    gate_len = 16'd64; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    t_arm = cyc;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (result_valid_s) ok = 1'b1;
    end
    chk("sat_strobe_seen", 32'(ok), 32'd1);
    chk("sat_latency", 32'(cyc - t_arm), 32'd65);

    // Zero-length gate.
    per[0] = 0; per[1] = 0;
    repeat (10) @(negedge clk);
    push(32'd0, 2'b00, 16'd1);
    start_meas(16'd0, 1'b0);
    wait_valid(20, ok);
    chk("zero_strobe_seen", 32'(ok), 32'd1);
    chk("zero_latency", 32'(cyc - t_arm), 32'd2);

    // Continuous mode, gate 20: ch0 every 5 clk (4/window), ch1 every 4 (5/window).
    per[0] = 5; per[1] = 4;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) push({16'd5, 16'd4}, 2'b00, 16'd20);
    start_meas(16'd20, 1'b1);
    wait_valid(100, ok);
    chk("cont_first_seen", 32'(ok), 32'd1);
    chk("cont_first_latency", 32'(cyc - t_arm), 32'd21);
    for (int i = 0; i < 3; i++) begin
      t_prev = cyc;
      // Drop continuous right after the third strobe: one more window follows.
      if (i == 2) continuous = 1'b0;
      wait_valid(100, ok);
      chk("cont_seen", 32'(ok), 32'd1);
      chk("cont_period", 32'(cyc - t_prev), 32'd21);
      if (i < 2) chk("cont_busy", 32'(busy), 32'd1);
    end
    chk("cont_busy_end", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("cont_no_extra", 32'(n_strobe), 32'(exp_strobe));

    // Start pulsed during GATE is ignored.
    per[0] = 3; per[1] = 6;
    repeat (20) @(negedge clk);
    push({16'd5, 16'd10}, 2'b00, 16'd30);
    start_meas(16'd30, 1'b0);
    repeat (10) @(negedge clk);
    gate_len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(100, ok);
    chk("busy_start_seen", 32'(ok), 32'd1);
    chk("busy_start_latency", 32'(cyc - t_arm), 32'd31);
    repeat (40) @(negedge clk);
    chk("busy_start_single", 32'(n_strobe), 32'(exp_strobe));

    // Reset in the middle of a 100-cycle window.
    start_meas(16'd100, 1'b0);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_gate_used", 32'(gate_used), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (130) @(negedge clk);
    chk("midrst_no_strobe", 32'(n_strobe), 32'(exp_strobe));
    chk("midrst_busy_after", 32'(busy), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("sat_sb_drained", 32'(sb_s.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
